// File: rtl/seq_ram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_ram_arb_pkg                                           |
// | Brief    : Shared types and constants for the sequencer RAM arbiter. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package seq_ram_arb_pkg;

   localparam int SEQ_RAM_ADDR_W = 10;
   localparam int SEQ_RAM_DATA_W = 32;
   localparam int SEQ_RAM_BE_W   = 4;
   localparam int SEQ_RAM_RD_LAT = 1;

   localparam int c_lock_cnt_w = 4;

   typedef enum logic {
      M_CPU = 1'b0,
      M_DBG = 1'b1
   } master_id_t;

   typedef struct packed {
      logic                    locked;
      master_id_t              owner;
      logic [c_lock_cnt_w-1:0] lock_cnt;
   } lock_state_t;

   // Saturating so an unlimited lock never wraps back to zero.
   function automatic logic [c_lock_cnt_w-1:0] lock_cnt_inc(input logic [c_lock_cnt_w-1:0] cnt);
      return (cnt == '1) ? cnt : cnt + 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_ram_arb_grant.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_ram_arb_grant                                         |
// | Brief    : Two-master grant logic: tie-break, lock and last_grant.   |
// |            SEQ_RAM_ARB_FIXED_PRIORITY_EN: master 0 always wins ties. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seq_ram_arb_grant
   import seq_ram_arb_pkg::*;
#(
   parameter int LOCK_MAX = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_lock0,
   input  logic i_lock1,
   output logic o_gnt0,
   output logic o_gnt1,
   output logic o_lock_timeout
);

   lock_state_t r_lock;
   logic        r_lock_timeout;
   logic        w_expired;
   logic        w_hold;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_any;
   logic        w_lock_req;
   master_id_t  w_gnt_id;

   generate
      if (LOCK_MAX != 0) begin : g_lock_limit
         assign w_expired = r_lock.locked && (r_lock.lock_cnt == c_lock_cnt_w'(LOCK_MAX));
      end else begin : g_lock_unlimited
         assign w_expired = 1'b0;
      end
   endgenerate

   assign w_hold = r_lock.locked && !w_expired;

`ifndef SEQ_RAM_ARB_FIXED_PRIORITY_EN
   master_id_t r_last_grant;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= M_DBG;
      end else if (w_any) begin
         r_last_grant <= w_gnt_id;
      end
   end
`endif

   // Grants are forced low in reset so both masters see waitrequest.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst) begin
         if (w_hold) begin
            if (r_lock.owner == M_CPU) begin
               w_gnt0 = i_req0;
            end else begin
               w_gnt1 = i_req1;
            end
         end else if (i_req0 && i_req1) begin
`ifdef SEQ_RAM_ARB_FIXED_PRIORITY_EN
            w_gnt0 = 1'b1;
`else
            if (r_last_grant == M_CPU) begin
               w_gnt1 = 1'b1;
            end else begin
               w_gnt0 = 1'b1;
            end
`endif
         end else begin
            w_gnt0 = i_req0;
            w_gnt1 = i_req1;
         end
      end
   end

   assign w_any      = w_gnt0 | w_gnt1;
   assign w_gnt_id   = w_gnt1 ? M_DBG : M_CPU;
   assign w_lock_req = w_gnt1 ? i_lock1 : i_lock0;

   // An expired lock is dropped on the grant that overrode it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lock         <= '0;
         r_lock_timeout <= 1'b0;
      end else if (w_any) begin
         if (w_expired) begin
            r_lock.locked   <= 1'b0;
            r_lock.lock_cnt <= '0;
            r_lock_timeout  <= 1'b1;
         end else if (w_lock_req) begin
            r_lock.locked   <= 1'b1;
            r_lock.owner    <= w_gnt_id;
            r_lock.lock_cnt <= lock_cnt_inc(r_lock.lock_cnt);
         end else begin
            r_lock.locked   <= 1'b0;
            r_lock.lock_cnt <= '0;
         end
      end
   end

   assign o_gnt0         = w_gnt0;
   assign o_gnt1         = w_gnt1;
   assign o_lock_timeout = r_lock_timeout;

endmodule
`default_nettype wire

// File: rtl/seq_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : seq_ram_arbiter                                           |
// | Brief    : Two-master arbiter for the sequencer 1024x32 RAM.         |
// |            SEQ_RAM_ARB_FIXED_PRIORITY_EN: master 0 always wins ties. |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module seq_ram_arbiter
   import seq_ram_arb_pkg::*;
#(
   parameter int ADDR_W   = SEQ_RAM_ADDR_W,
   parameter int DATA_W   = SEQ_RAM_DATA_W,
   parameter int BE_W     = SEQ_RAM_BE_W,
   parameter int LOCK_MAX = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   input  logic              m0_lock,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   input  logic              m1_lock,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] ram_address,
   output logic [BE_W-1:0]   ram_byteenable,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   output logic              ram_clken,
   input  logic [DATA_W-1:0] ram_readdata,
   output logic              lock_timeout
);

   logic       w_req0;
   logic       w_req1;
   logic       w_gnt0;
   logic       w_gnt1;
   logic       w_rd_go;
   logic       w_rd_done;
   master_id_t w_gnt_id;

   logic       r_rd_pend [SEQ_RAM_RD_LAT];
   master_id_t r_rd_tag  [SEQ_RAM_RD_LAT];

   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;

   seq_ram_arb_grant #(
      .LOCK_MAX (LOCK_MAX)
   ) u_grant (
      .clk            (clk),
      .rst            (reset),
      .i_req0         (w_req0),
      .i_req1         (w_req1),
      .i_lock0        (m0_lock),
      .i_lock1        (m1_lock),
      .o_gnt0         (w_gnt0),
      .o_gnt1         (w_gnt1),
      .o_lock_timeout (lock_timeout)
   );

   assign w_gnt_id = w_gnt1 ? M_DBG : M_CPU;

   assign m0_waitrequest = ~(w_req0 & w_gnt0);
   assign m1_waitrequest = ~(w_req1 & w_gnt1);

   // A write wins over a simultaneous read from the same master.
   always_comb begin
      ram_address    = '0;
      ram_byteenable = '0;
      ram_writedata  = '0;
      ram_write      = 1'b0;
      ram_chipselect = 1'b0;
      w_rd_go        = 1'b0;
      if (w_gnt0) begin
         ram_address    = m0_address;
         ram_byteenable = m0_byteenable;
         ram_writedata  = m0_writedata;
         ram_write      = m0_write;
         ram_chipselect = 1'b1;
         w_rd_go        = m0_read & ~m0_write;
      end else if (w_gnt1) begin
         ram_address    = m1_address;
         ram_byteenable = m1_byteenable;
         ram_writedata  = m1_writedata;
         ram_write      = m1_write;
         ram_chipselect = 1'b1;
         w_rd_go        = m1_read & ~m1_write;
      end
   end

   assign ram_clken = 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SEQ_RAM_RD_LAT; i++) begin
            r_rd_pend[i] <= 1'b0;
            r_rd_tag[i]  <= M_CPU;
         end
      end else begin
         r_rd_pend[0] <= w_rd_go;
         r_rd_tag[0]  <= w_gnt_id;
         for (int i = 1; i < SEQ_RAM_RD_LAT; i++) begin
            r_rd_pend[i] <= r_rd_pend[i-1];
            r_rd_tag[i]  <= r_rd_tag[i-1];
         end
      end
   end

   // Gating with reset hides a read that was in flight when reset arrived.
   assign w_rd_done        = r_rd_pend[SEQ_RAM_RD_LAT-1] & ~reset;
   assign m0_readdatavalid = w_rd_done & (r_rd_tag[SEQ_RAM_RD_LAT-1] == M_CPU);
   assign m1_readdatavalid = w_rd_done & (r_rd_tag[SEQ_RAM_RD_LAT-1] == M_DBG);

   assign m0_readdata = ram_readdata;
   assign m1_readdata = ram_readdata;

endmodule
`default_nettype wire

// File: tb/tb_seq_ram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_seq_ram_arbiter                                        |
// | Brief    : Scoreboard bench for seq_ram_arbiter with a RAM model.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_seq_ram_arbiter;

   logic        clk;
   logic        reset;
   logic [9:0]  m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m0_lock;
   logic        m1_read, m1_write, m1_lock;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [9:0]  ram_address;
   logic [3:0]  ram_byteenable;
   logic        ram_chipselect, ram_write, ram_clken;
   logic [31:0] ram_writedata, ram_readdata;
   logic        lock_timeout;

   typedef struct {
      logic        tag;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          cycle;
   int          n_checks;
   int          n_pass;
   logic [31:0] mem [1024];

   seq_ram_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_lock          (m0_lock),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_lock          (m1_lock),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .ram_address      (ram_address),
      .ram_byteenable   (ram_byteenable),
      .ram_chipselect   (ram_chipselect),
      .ram_write        (ram_write),
      .ram_writedata    (ram_writedata),
      .ram_clken        (ram_clken),
      .ram_readdata     (ram_readdata),
      .lock_timeout     (lock_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // RAM model: preloaded with 0xA500_0000 | address while reset is high.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      end else if (ram_chipselect && ram_clken) begin
         if (ram_write) begin
            for (int b = 0; b < 4; b++)
               if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
         end else begin
            ram_readdata <= mem[ram_address];
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic set_m0(input logic rd, input logic wr, input logic lk,
                         input logic [9:0] addr, input logic [3:0] be, input logic [31:0] wd);
      m0_read = rd; m0_write = wr; m0_lock = lk;
      m0_address = addr; m0_byteenable = be; m0_writedata = wd;
   endtask

   task automatic set_m1(input logic rd, input logic wr, input logic lk,
                         input logic [9:0] addr, input logic [3:0] be, input logic [31:0] wd);
      m1_read = rd; m1_write = wr; m1_lock = lk;
      m1_address = addr; m1_byteenable = be; m1_writedata = wd;
   endtask

   task automatic idle_all();
      set_m0(1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
      set_m1(1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
   endtask

   // The read issued this cycle must come back on the following cycle.
   task automatic expect_rd(input logic tag, input logic [31:0] data);
      exp_t e;
      e.tag  = tag;
      e.data = data;
      e.cyc  = cycle + 1;
      sb.push_back(e);
   endtask

   task automatic tick(input string name, input logic w0, input logic w1, input logic lto);
      @(negedge clk);
      check({name, "_m0_wait"}, 64'(m0_waitrequest), 64'(w0));
      check({name, "_m1_wait"}, 64'(m1_waitrequest), 64'(w1));
      check({name, "_lock_timeout"}, 64'(lock_timeout), 64'(lto));
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (m0_readdatavalid || m1_readdatavalid) begin
         if (sb.size() == 0) begin
            check("rdv_unexpected", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
         end else begin
            mon_e = sb.pop_front();
            check("rdv_m0", 64'(m0_readdatavalid), 64'(!mon_e.tag));
            check("rdv_m1", 64'(m1_readdatavalid), 64'(mon_e.tag));
            check("rd_data", 64'(mon_e.tag ? m1_readdata : m0_readdata), 64'(mon_e.data));
            check("rd_cycle", 64'(cycle), 64'(mon_e.cyc));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      idle_all();
      @(posedge clk); #1;
      @(posedge clk); #1;

      // Requests during reset are held off.
      set_m0(1'b1, 1'b0, 1'b0, 10'h010, 4'hF, 32'h0);
      set_m1(1'b1, 1'b0, 1'b0, 10'h020, 4'hF, 32'h0);
      #3 check("rst_chipselect", 64'(ram_chipselect), 64'(0));
      check("rst_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
      tick("rst", 1'b1, 1'b1, 1'b0);
      reset = 1'b0;

      // Continuous tie straight after reset: grants alternate 0, 1, 0, 1.
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) begin
            expect_rd(1'b0, 32'hA500_0010);
            tick("t2_m0", 1'b0, 1'b1, 1'b0);
         end else begin
            expect_rd(1'b1, 32'hA500_0020);
            tick("t2_m1", 1'b1, 1'b0, 1'b0);
         end
      end

      // m0 alone: write then read back the same word.
      set_m1(1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
      set_m0(1'b0, 1'b1, 1'b0, 10'h005, 4'hF, 32'hDEAD_BEEF);
      tick("t1_wr", 1'b0, 1'b1, 1'b0);
      set_m0(1'b1, 1'b0, 1'b0, 10'h005, 4'hF, 32'h0);
      expect_rd(1'b0, 32'hDEAD_BEEF);
      tick("t1_rd", 1'b0, 1'b1, 1'b0);

      // m1 partial write over an all-ones word.
      set_m0(1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
      set_m1(1'b0, 1'b1, 1'b0, 10'h030, 4'hF, 32'hFFFF_FFFF);
      tick("t3_wr_full", 1'b1, 1'b0, 1'b0);
      set_m1(1'b0, 1'b1, 1'b0, 10'h030, 4'h3, 32'h1122_3344);
      tick("t3_wr_be", 1'b1, 1'b0, 1'b0);
      set_m1(1'b1, 1'b0, 1'b0, 10'h030, 4'hF, 32'h0);
      expect_rd(1'b1, 32'hFFFF_3344);
      tick("t3_rd", 1'b1, 1'b0, 1'b0);

      // m0 locks for 3 accesses with an idle gap; m1 waits throughout.
      set_m1(1'b1, 1'b0, 1'b0, 10'h020, 4'hF, 32'h0);
      set_m0(1'b1, 1'b0, 1'b1, 10'h005, 4'hF, 32'h0);
      expect_rd(1'b0, 32'hDEAD_BEEF);
      tick("t4_lk1", 1'b0, 1'b1, 1'b0);
      set_m0(1'b0, 1'b0, 1'b0, 10'h005, 4'hF, 32'h0);
      tick("t4_idle", 1'b1, 1'b1, 1'b0);
      set_m0(1'b1, 1'b0, 1'b1, 10'h005, 4'hF, 32'h0);
      expect_rd(1'b0, 32'hDEAD_BEEF);
      tick("t4_lk2", 1'b0, 1'b1, 1'b0);
      expect_rd(1'b0, 32'hDEAD_BEEF);
      tick("t4_lk3", 1'b0, 1'b1, 1'b0);
      set_m0(1'b1, 1'b0, 1'b0, 10'h005, 4'hF, 32'h0);
      expect_rd(1'b0, 32'hDEAD_BEEF);
      tick("t4_unlk", 1'b0, 1'b1, 1'b0);
      set_m0(1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
      expect_rd(1'b1, 32'hA500_0020);
      tick("t4_m1", 1'b1, 1'b0, 1'b0);

      // m0 holds lock continuously: 15 grants, then m1 forces its way in.
      set_m0(1'b1, 1'b0, 1'b1, 10'h010, 4'hF, 32'h0);
      for (int k = 0; k < 15; k++) begin
         expect_rd(1'b0, 32'hA500_0010);
         tick("t5_locked", 1'b0, 1'b1, 1'b0);
      end
      expect_rd(1'b1, 32'hA500_0020);
      tick("t5_release", 1'b1, 1'b0, 1'b0);
      idle_all();
      tick("t5_sticky1", 1'b1, 1'b1, 1'b1);
      tick("t5_sticky2", 1'b1, 1'b1, 1'b1);

      // Reset the cycle after a granted, locking m1 read.
      set_m1(1'b1, 1'b0, 1'b1, 10'h020, 4'hF, 32'h0);
      tick("t6_m1_rd", 1'b1, 1'b0, 1'b1);
      reset = 1'b1;
      idle_all();
      #3 check("t6_rst_rdv", 64'({m0_readdatavalid, m1_readdatavalid}), 64'(0));
      tick("t6_rst", 1'b1, 1'b1, 1'b1);
      reset = 1'b0;
      set_m0(1'b1, 1'b0, 1'b0, 10'h010, 4'hF, 32'h0);
      set_m1(1'b1, 1'b0, 1'b0, 10'h020, 4'hF, 32'h0);
      expect_rd(1'b0, 32'hA500_0010);
      tick("t6_tie", 1'b0, 1'b1, 1'b0);
      expect_rd(1'b1, 32'hA500_0020);
      tick("t6_rr", 1'b1, 1'b0, 1'b0);
      idle_all();
      repeat (3) tick("drain", 1'b1, 1'b1, 1'b0);

      check("sb_empty", 64'(sb.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
